// File: rtl/intrusion_detector_if.sv
// Sensor-side and alarm-side signals of the intrusion detector, grouped as one bundle.
// The master side supplies samples, threshold and arm request; the slave side is the detector.
interface intrusion_detector_if;
    logic [7:0] Distance;
    logic       Dist_Valid;
    logic [7:0] Threshold;
    logic       Arm;
    logic [2:0] State;
    logic       Armed;
    logic       Alarm;
    logic       Buzzer;
    logic [7:0] Intrusion_Count;

    modport master (
        output Distance, Dist_Valid, Threshold, Arm,
        input  State, Armed, Alarm, Buzzer, Intrusion_Count
    );

    modport slave (
        input  Distance, Dist_Valid, Threshold, Arm,
        output State, Armed, Alarm, Buzzer, Intrusion_Count
    );
endinterface

// File: rtl/intrusion_detector.sv
// Intrusion detector: filters distance samples into a detection and sequences
// the arm / exit-delay / entry-delay / alarm behaviour. All outputs are registered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// DISARMED   | idle, samples ignored, waiting for Arm=1
// EXIT_DELAY | EXIT_TICKS ticks for the occupant to leave, samples ignored
// ARMED      | counting consecutive near samples, detect -> PRE_ALARM
// PRE_ALARM  | ENTRY_TICKS ticks of warning tone before the alarm
// ALARM      | alarm latched until Arm=0
module intrusion_detector #(
    parameter int TICK_DIV    = 100000,
    parameter int EXIT_TICKS  = 10,
    parameter int ENTRY_TICKS = 5,
    parameter int HITS        = 3,
    parameter int BUZZ_DIV    = 50
) (
    input  logic                 CLK,
    input  logic                 RST,
    intrusion_detector_if.slave  bus
);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMR_MAX = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BUZZ_W  = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam int HIT_W   = 4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_DIV - 1);
    localparam logic [TMR_W-1:0]  TMR_EXIT  = TMR_W'(EXIT_TICKS);
    localparam logic [TMR_W-1:0]  TMR_ENTRY = TMR_W'(ENTRY_TICKS);
    localparam logic [HIT_W-1:0]  HIT_MAX   = HIT_W'(HITS);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_EXIT     = 3'd1,
        S_ARMED    = 3'd2,
        S_PRE      = 3'd3,
        S_ALARM    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [HIT_W-1:0]    hit_q, hit_d;
    logic [BUZZ_W-1:0]   buzz_cnt_q, buzz_cnt_d;
    logic                buzzer_q, buzzer_d;
    logic                armed_q, armed_d;
    logic                alarm_q, alarm_d;
    logic [7:0]          count_q, count_d;
    logic                tick, near, far, detect, state_chg, timer_last;

    // State register and all datapath flops, synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_DISARMED;
            tick_cnt_q <= '0;
            timer_q    <= '0;
            hit_q      <= '0;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
            armed_q    <= 1'b0;
            alarm_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            timer_q    <= timer_d;
            hit_q      <= hit_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
            armed_q    <= armed_d;
            alarm_q    <= alarm_d;
            count_q    <= count_d;
        end
    end

    // Sample classification and the consecutive-near hit filter.
    // detect looks at the updated count so the sample completing the run acts this cycle.
    always_comb begin
        near   = bus.Dist_Valid && (bus.Distance != 8'd0) && (bus.Distance < bus.Threshold);
        far    = bus.Dist_Valid && (bus.Distance != 8'd0) && !(bus.Distance < bus.Threshold);
        hit_d  = '0;
        if (state_q == S_ARMED) begin
            if (near) begin
                hit_d = (hit_q == HIT_MAX) ? HIT_MAX : hit_q + HIT_W'(1);
            end else if (far) begin
                hit_d = '0;
            end else begin
                hit_d = hit_q;
            end
        end
        detect     = (hit_d == HIT_MAX);
        tick       = (tick_cnt_q == TICK_LAST);
        timer_last = tick && (timer_q == TMR_W'(1));
    end

    // Next-state logic; Arm=0 overrides every other cause.
    always_comb begin
        state_d = state_q;
        if (!bus.Arm) begin
            state_d = S_DISARMED;
        end else begin
            case (state_q)
                S_DISARMED: state_d = S_EXIT;
                S_EXIT:     if (timer_last) state_d = S_ARMED;
                S_ARMED:    if (detect)     state_d = S_PRE;
                S_PRE:      if (timer_last) state_d = S_ALARM;
                S_ALARM:    state_d = S_ALARM;
                default:    state_d = S_DISARMED;
            endcase
        end
    end

    // Output and counter updates derived from the transition being taken.
    always_comb begin
        state_chg  = (state_d != state_q);
        tick_cnt_d = (state_chg || tick) ? '0 : tick_cnt_q + TICK_W'(1);

        timer_d = timer_q;
        if (state_chg) begin
            case (state_d)
                S_EXIT:  timer_d = TMR_EXIT;
                S_PRE:   timer_d = TMR_ENTRY;
                default: timer_d = '0;
            endcase
        end else if (tick && (timer_q != '0) && (state_q == S_EXIT || state_q == S_PRE)) begin
            timer_d = timer_q - TMR_W'(1);
        end

        armed_d = (state_d == S_ARMED) || (state_d == S_PRE) || (state_d == S_ALARM);
        alarm_d = (state_d == S_ALARM);

        buzz_cnt_d = '0;
        buzzer_d   = 1'b0;
        if (state_d == S_ALARM) begin
            buzzer_d = 1'b1;
        end else if (state_d == S_PRE && state_q == S_PRE) begin
            if (buzz_cnt_q == BUZZ_LAST) begin
                buzz_cnt_d = '0;
                buzzer_d   = ~buzzer_q;
            end else begin
                buzz_cnt_d = buzz_cnt_q + BUZZ_W'(1);
                buzzer_d   = buzzer_q;
            end
        end

        count_d = count_q;
        if (state_q == S_PRE && state_d == S_ALARM && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    assign bus.State           = state_q;
    assign bus.Armed           = armed_q;
    assign bus.Alarm           = alarm_q;
    assign bus.Buzzer          = buzzer_q;
    assign bus.Intrusion_Count = count_q;
endmodule
